// File: rtl/uart_rx_check.sv
// 8N1 UART receiver feeding a four-byte sequence checker.
// The receiver strobes each framed byte or framing error, and the checker scores an armed run against EXP0..EXP3.
module uart_rx_check #(
   parameter int         CLKS_PER_BIT = 868,
   parameter logic [7:0] EXP0 = 8'h41,
   parameter logic [7:0] EXP1 = 8'h55,
   parameter logic [7:0] EXP2 = 8'h66,
   parameter logic [7:0] EXP3 = 8'h7A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   input  logic       arm,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       done,
   output logic       pass,
   output logic [2:0] char_cnt
);
   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [2:0] R_IDLE  = 3'd0;
   localparam logic [2:0] R_START = 3'd1;
   localparam logic [2:0] R_DATA  = 3'd2;
   localparam logic [2:0] R_STOP  = 3'd3;
   localparam logic [2:0] R_BREAK = 3'd4;

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_RUN  = 2'd1;
   localparam logic [1:0] C_DONE = 2'd2;

   logic          sync1_q, sync2_q;
   logic [2:0]    rstate_q, rstate_d;
   logic [CW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   logic [1:0]    cstate_q, cstate_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          mis_q, mis_d;
   logic          pass_q, pass_d;
   logic [7:0]    exp_byte;
   logic          slot_bad;

   always_comb begin
      rstate_d = rstate_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (!sync2_q) begin
               rstate_d = R_START;
               tick_d   = '0;
               bit_d    = '0;
            end
         end
         R_START: begin
            // A line that is high again at mid start bit was a glitch.
            if (tick_q == HALF_M1) begin
               tick_d   = '0;
               rstate_d = sync2_q ? R_IDLE : R_DATA;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         R_DATA: begin
            if (tick_q == FULL_M1) begin
               tick_d  = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) rstate_d = R_STOP;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         R_STOP: begin
            if (tick_q == FULL_M1) begin
               tick_d = '0;
               if (sync2_q) begin
                  data_d   = shift_q;
                  valid_d  = 1'b1;
                  rstate_d = R_IDLE;
               end else begin
                  ferr_d   = 1'b1;
                  rstate_d = R_BREAK;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         R_BREAK: if (sync2_q) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      case (cnt_q[1:0])
         2'd0:    exp_byte = EXP0;
         2'd1:    exp_byte = EXP1;
         2'd2:    exp_byte = EXP2;
         default: exp_byte = EXP3;
      endcase
   end

   assign slot_bad = ferr_q | (data_q != exp_byte);

   always_comb begin
      cstate_d = cstate_q;
      cnt_d    = cnt_q;
      mis_d    = mis_q;
      pass_d   = pass_q;
      case (cstate_q)
         C_IDLE: begin
            if (arm) begin
               cstate_d = C_RUN;
               cnt_d    = '0;
               mis_d    = 1'b0;
            end
         end
         C_RUN: begin
            // A framing error still consumes its slot so the run always ends after four strobes.
            if (valid_q || ferr_q) begin
               mis_d = mis_q | slot_bad;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd3) begin
                  cstate_d = C_DONE;
                  pass_d   = ~(mis_q | slot_bad);
               end
            end
         end
         C_DONE:  if (!arm) cstate_d = C_IDLE;
         default: cstate_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         rstate_q <= R_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         cstate_q <= C_IDLE;
         cnt_q    <= '0;
         mis_q    <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         sync1_q  <= uart_rx;
         sync2_q  <= sync1_q;
         rstate_q <= rstate_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         cstate_q <= cstate_d;
         cnt_q    <= cnt_d;
         mis_q    <= mis_d;
         pass_q   <= pass_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign done      = (cstate_q == C_DONE);
   assign pass      = pass_q;
   assign char_cnt  = cnt_q;
endmodule

// File: tb/tb_uart_rx_check.sv
// Randomized serial-frame bench for uart_rx_check with an in-bench model of the expected strobes and the checker score.
module tb_uart_rx_check;
   localparam int CPB = 8;
   localparam logic [7:0] ETAB [4] = '{8'h41, 8'h55, 8'h66, 8'h7A};

   logic       clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, arm = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, done, pass;
   logic [2:0] char_cnt;

   uart_rx_check #(.CLKS_PER_BIT(CPB), .EXP0(ETAB[0]), .EXP1(ETAB[1]),
                   .EXP2(ETAB[2]), .EXP3(ETAB[3])) dut (
      .clk(clk), .rst(rst), .uart_rx(uart_rx), .arm(arm),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .done(done), .pass(pass), .char_cnt(char_cnt));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at cycle %0d", nm, act, expv, cyc);
      end
   endtask

   typedef struct { bit err; logic [7:0] d; int t0; } exp_t;
   exp_t expq[$];

   // Model: every frame the bench sends yields exactly one strobe; an armed run scores the next four.
   bit         chk_en = 0;
   bit         m_run = 0, m_done = 0, m_pass = 0, m_mis = 0;
   int         m_cnt = 0;
   logic [7:0] m_rx = 8'h00;

   always @(negedge clk) begin
      exp_t e;
      bit   hit;
      hit = 0;
      if (chk_en) begin
         chk("char_cnt", char_cnt, m_cnt);
         chk("done", done, m_done);
         if (m_done) chk("pass", pass, m_pass);
         chk("both_strobes", rx_valid & frame_err, 0);
         if (rx_valid || frame_err) begin
            if (expq.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
               e   = expq.pop_front();
               hit = 1;
               chk("strobe_is_ferr", frame_err, e.err);
               chk("latency_in_window", (cyc - e.t0 >= 76) && (cyc - e.t0 <= 80), 1);
               if (!e.err) begin
                  chk("rx_data_new", rx_data, e.d);
                  m_rx = e.d;
               end
            end
         end
         if (!rx_valid) chk("rx_data_hold", rx_data, m_rx);
      end
      if (rst) begin
         m_run = 0; m_done = 0; m_pass = 0; m_mis = 0; m_cnt = 0; m_rx = 8'h00;
      end else if (m_done) begin
         if (!arm) m_done = 0;
      end else if (m_run) begin
         if (hit) begin
            m_mis = m_mis | e.err | (e.d != ETAB[m_cnt]);
            m_cnt++;
            if (m_cnt == 4) begin
               m_run = 0; m_done = 1; m_pass = !m_mis;
            end
         end
      end else if (arm) begin
         m_run = 1; m_cnt = 0; m_mis = 0;
      end
   end

   // All line drives start 1 time unit after a rising edge and hold for whole cycles.
   task automatic drive(input logic v, input int n);
      uart_rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit bad_stop);
      exp_t e;
      e.err = bad_stop; e.d = b; e.t0 = cyc;
      expq.push_back(e);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      if (bad_stop) drive(1'b0, 2 * CPB);
      drive(1'b1, CPB);
   endtask

   task automatic idle(input int n);
      drive(1'b1, n);
   endtask

   task automatic settle_check(input string nm);
      idle(2 * CPB);
      chk(nm, expq.size(), 0);
   endtask

   initial begin
      logic [7:0] b;
      bit         bad;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1;
      @(negedge clk);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_char_cnt", char_cnt, 0);
      @(posedge clk); #1;

      // Unarmed traffic is received but not scored.
      send(8'h3C, 0);
      send(8'h41, 0);
      settle_check("unarmed_lost");
      @(negedge clk);
      chk("unarmed_char_cnt", char_cnt, 0);
      chk("unarmed_done", done, 0);
      @(posedge clk); #1;

      // Matching sequence, back to back.
      arm = 1'b1;
      idle(2);
      for (int k = 0; k < 4; k++) send(ETAB[k], 0);
      idle(4);
      @(negedge clk);
      chk("match_done", done, 1);
      chk("match_pass", pass, 1);
      chk("match_char_cnt", char_cnt, 4);
      @(posedge clk); #1;
      arm = 1'b0;
      @(negedge clk);
      chk("release_done_held", done, 1);
      @(posedge clk); @(negedge clk);
      chk("release_done_clear", done, 0);
      @(posedge clk); #1;
      idle(4);

      // Third byte wrong.
      arm = 1'b1;
      idle(2);
      send(8'h41, 0); send(8'h55, 0); send(8'h67, 0); send(8'h7A, 0);
      idle(4);
      @(negedge clk);
      chk("mismatch_done", done, 1);
      chk("mismatch_pass", pass, 0);
      chk("mismatch_rx_data", rx_data, 8'h7A);
      @(posedge clk); #1;
      arm = 1'b0;
      idle(4);

      // Stop bit held low, then a clean frame.
      send(8'h55, 1);
      idle(CPB);
      send(8'h41, 0);
      settle_check("ferr_lost");

      // Short glitch on the idle line is rejected; a real frame still follows.
      drive(1'b0, 3);
      idle(3 * CPB);
      chk("glitch_no_strobe_pending", expq.size(), 0);
      send(8'hC3, 0);
      settle_check("post_glitch_lost");

      // Reset in the middle of bit 4 drops the partial byte.
      b = 8'h3C;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(b[i], CPB);
      drive(b[4], CPB / 2);
      rst = 1'b1; uart_rx = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(2 * CPB);
      send(8'hA5, 0);
      settle_check("post_rst_lost");
      @(negedge clk);
      chk("post_rst_rx_data", rx_data, 8'hA5);
      @(posedge clk); #1;

      // Randomized runs: mostly expected bytes, some corrupted, some framing errors, arm dropped mid-run.
      for (int it = 0; it < 8; it++) begin
         arm = 1'b1;
         idle(2);
         for (int k = 0; k < 4; k++) begin
            b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ETAB[k];
            bad = ($urandom_range(0, 7) == 0);
            send(b, bad);
            if (it[0] && k == 1) arm = 1'b0;
            idle($urandom_range(0, 2 * CPB));
         end
         settle_check("rand_lost");
         arm = 1'b0;
         idle(4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_check.md
UART_RX_CHECK -- requirements
Module: uart_rx_check

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit; SHALL be >= 4.
REQ-002 Parameters EXP0..EXP3, default 8'h41, 8'h55, 8'h66, 8'h7A, the expected byte sequence in order.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 uart_rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 arm  input  1  level request to start a 4-byte check; driven from a debounced button.
REQ-007 rx_data  output  8  last correctly framed byte.
REQ-008 rx_valid  output  1  one-cycle strobe; rx_data is new.
REQ-009 frame_err  output  1  one-cycle strobe; stop bit sampled low.
REQ-010 done  output  1  high while the checker is in C_DONE.
REQ-011 pass  output  1  valid while done is high; 1 = all four bytes matched.
REQ-012 char_cnt  output  3  bytes consumed in the current check, 0..4.

Function -- receiver
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all receiver decisions use the synchronized value.
REQ-014 Receiver states SHALL be R_IDLE, R_START, R_DATA, R_STOP, R_BREAK.
REQ-015 R_IDLE -> R_START on synchronized line = 0; bit counter cleared.
REQ-016 R_START: after CLKS_PER_BIT/2 cycles (integer division), resample; 0 -> R_DATA, 1 -> R_IDLE with no strobe (glitch rejected).
REQ-017 R_DATA: sample every CLKS_PER_BIT cycles; shift LSB first; after the 8th sample -> R_STOP.
REQ-018 R_STOP: sample CLKS_PER_BIT cycles after bit 7; 1 -> load rx_data, pulse rx_valid, -> R_IDLE; 0 -> pulse frame_err, rx_data unchanged, -> R_BREAK.
REQ-019 R_BREAK -> R_IDLE on the first cycle the synchronized line is 1.
REQ-020 rx_valid and frame_err SHALL be registered, each high exactly one cycle, never both in the same cycle.
REQ-021 Falling edge on uart_rx to rx_valid rising SHALL be 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, +/-2.
REQ-022 Back-to-back frames with stop bit of exactly one bit time SHALL be received without loss.

Function -- checker
REQ-023 Checker states SHALL be C_IDLE, C_RUN, C_DONE.
REQ-024 C_IDLE: arm = 1 -> C_RUN; char_cnt <= 0; sticky mismatch flag cleared; received bytes in C_IDLE are ignored by the checker.
REQ-025 C_RUN: on rx_valid, compare rx_data with EXP[char_cnt]; inequality sets mismatch; char_cnt increments.
REQ-026 C_RUN: on frame_err, set mismatch and increment char_cnt (slot consumed).
REQ-027 When char_cnt reaches 4 -> C_DONE; pass <= ~mismatch (including the 4th byte's result).
REQ-028 C_DONE: done = 1; further strobes ignored; char_cnt holds 4; arm = 0 -> C_IDLE.
REQ-029 arm falling during C_RUN SHALL NOT abort the check.
REQ-030 char_cnt SHALL never exceed 4 (no wrap).

Reset
REQ-031 rst SHALL synchronously force R_IDLE, C_IDLE, synchronizer flops 1, rx_data 8'h00, rx_valid 0, frame_err 0, done 0, pass 0, char_cnt 0, all counters 0.
REQ-032 rst asserted mid-frame SHALL discard the partial byte with no strobe; the receiver then needs a fresh falling edge.

Verification (CLKS_PER_BIT = 8)
REQ-033 arm = 1, send 41,55,66,7A back-to-back -> four rx_valid strobes with those values, char_cnt 1..4, done = 1, pass = 1.
REQ-034 arm = 1, send 41,55,67,7A -> done = 1, pass = 0; rx_data = 8'h7A after the last strobe.
REQ-035 Send 0x55 with stop bit held low 2 bit times -> frame_err one cycle, no rx_valid, next 0x41 after line high is received correctly.
REQ-036 Low pulse of 3 cycles on idle line -> no strobe; receiver back in R_IDLE.
REQ-037 rst during bit 4 of a frame, then a full 0xA5 frame -> no strobe for the aborted frame, rx_valid with rx_data = 8'hA5.
REQ-038 Bytes sent with arm = 0 -> rx_valid strobes occur, char_cnt stays 0, done stays 0; arm released in C_DONE -> done = 0 next cycle.
